// File: rtl/axil_pkg.sv
// Shared constants, state encodings and helpers for the AXI4-Lite register slave.
// Imported by axil_slave_regs.
package axil_pkg;

    localparam int AXIL_AW = 32;
    localparam int AXIL_DW = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int REG_CTRL     = 0;
    localparam int REG_STATUS   = 1;
    localparam int REG_PEND     = 2;
    localparam int REG_SCRATCH0 = 3;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    // Expand a 4-bit byte strobe into a 32-bit bit mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/axil_slave_regs.sv
// AXI4-Lite register slave: CTRL, STATUS, W1C PEND and scratch registers,
// with independent read/write channel FSMs and a level interrupt.
module axil_slave_regs
    import axil_pkg::*;
#(
    parameter int          NUM_REGS    = 8,
    parameter logic [31:0] SCRATCH_RST = 32'h0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [AXIL_AW-1:0] S_AXIL_AWADDR,
    input  logic               S_AXIL_AWVALID,
    output logic               S_AXIL_AWREADY,
    input  logic [AXIL_DW-1:0] S_AXIL_WDATA,
    input  logic [3:0]         S_AXIL_WSTRB,
    input  logic               S_AXIL_WVALID,
    output logic               S_AXIL_WREADY,
    output logic [1:0]         S_AXIL_BRESP,
    output logic               S_AXIL_BVALID,
    input  logic               S_AXIL_BREADY,
    input  logic [AXIL_AW-1:0] S_AXIL_ARADDR,
    input  logic               S_AXIL_ARVALID,
    output logic               S_AXIL_ARREADY,
    output logic [AXIL_DW-1:0] S_AXIL_RDATA,
    output logic [1:0]         S_AXIL_RRESP,
    output logic               S_AXIL_RVALID,
    input  logic               S_AXIL_RREADY,
    input  logic [31:0]        status_i,
    input  logic [31:0]        event_i,
    output logic [31:0]        ctrl_o,
    output logic               irq_o
);

    localparam int IW = $clog2(NUM_REGS);

    // Write channel state
    w_state_e           w_state_q;
    logic               aw_held_q;
    logic               w_held_q;
    logic               awready_q;
    logic               wready_q;
    logic               bvalid_q;
    logic [1:0]         bresp_q;
    logic [AXIL_AW-1:0] awaddr_q;
    logic [AXIL_DW-1:0] wdata_q;
    logic [3:0]         wstrb_q;

    // Read channel state
    r_state_e           r_state_q;
    logic               arready_q;
    logic               rvalid_q;
    logic [1:0]         rresp_q;
    logic [AXIL_DW-1:0] rdata_q;

    // Register file
    logic [31:0] ctrl_q;
    logic [31:0] ctrl_d;
    logic [31:0] pend_q;
    logic [31:0] pend_d;
    logic        irq_q;
    logic        irq_d;
    logic [31:0] scratch_q [REG_SCRATCH0:NUM_REGS-1];
    logic [31:0] scratch_d [REG_SCRATCH0:NUM_REGS-1];

    // Write-side decode
    logic               aw_fire;
    logic               w_fire;
    logic               wr_commit;
    logic               wr_hit;
    logic [AXIL_AW-1:0] wr_addr;
    logic [AXIL_DW-1:0] wr_data;
    logic [3:0]         wr_strb;
    logic [31:0]        wr_mask;
    logic [IW-1:0]      wr_idx;
    logic               wr_oor;
    logic [31:0]        pend_clr;

    // Read-side decode
    logic [IW-1:0]      rd_idx;
    logic               rd_oor;
    logic [31:0]        rd_val;

    // The top nibble selects the 0x4xxx_xxxx window upstream and byte
    // offset bits are don't-care, so neither participates in decode.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{wr_addr[1:0], wr_addr[AXIL_AW-1:28],
                                S_AXIL_ARADDR[1:0],
                                S_AXIL_ARADDR[AXIL_AW-1:28]};

    // Pick held or live AW/W beats and decide whether a write commits now.
    always_comb begin
        aw_fire   = S_AXIL_AWVALID && awready_q;
        w_fire    = S_AXIL_WVALID && wready_q;
        wr_addr   = aw_held_q ? awaddr_q : S_AXIL_AWADDR;
        wr_data   = w_held_q ? wdata_q : S_AXIL_WDATA;
        wr_strb   = w_held_q ? wstrb_q : S_AXIL_WSTRB;
        wr_idx    = wr_addr[2 +: IW];
        wr_oor    = |wr_addr[27:IW+2];
        wr_commit = (w_state_q == W_IDLE)
                 && (aw_held_q || aw_fire)
                 && (w_held_q || w_fire);
        wr_hit    = wr_commit && !wr_oor;
        wr_mask   = strb_mask(wr_strb);
    end

    // Next register contents; event sets are applied after W1C so set wins.
    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_hit && wr_idx == IW'(REG_CTRL)) begin
            ctrl_d = (ctrl_q & ~wr_mask) | (wr_data & wr_mask);
        end
        pend_clr = '0;
        if (wr_hit && wr_idx == IW'(REG_PEND)) begin
            pend_clr = wr_data & wr_mask;
        end
        pend_d = (pend_q & ~pend_clr) | event_i;
        irq_d  = |(pend_q & ctrl_q);
        for (int i = REG_SCRATCH0; i < NUM_REGS; i++) begin
            scratch_d[i] = scratch_q[i];
            if (wr_hit && wr_idx == IW'(i)) begin
                scratch_d[i] = (scratch_q[i] & ~wr_mask)
                             | (wr_data & wr_mask);
            end
        end
    end

    // Read mux over the current (pre-write) register values.
    always_comb begin
        rd_idx = S_AXIL_ARADDR[2 +: IW];
        rd_oor = |S_AXIL_ARADDR[27:IW+2];
        if (rd_oor) begin
            rd_val = '0;
        end else if (rd_idx == IW'(REG_CTRL)) begin
            rd_val = ctrl_q;
        end else if (rd_idx == IW'(REG_STATUS)) begin
            rd_val = status_i;
        end else if (rd_idx == IW'(REG_PEND)) begin
            rd_val = pend_q;
        end else begin
            rd_val = scratch_q[rd_idx];
        end
    end

    // Register file and interrupt flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q <= '0;
            pend_q <= '0;
            irq_q  <= 1'b0;
            for (int i = REG_SCRATCH0; i < NUM_REGS; i++) begin
                scratch_q[i] <= SCRATCH_RST;
            end
        end else begin
            ctrl_q <= ctrl_d;
            pend_q <= pend_d;
            irq_q  <= irq_d;
            for (int i = REG_SCRATCH0; i < NUM_REGS; i++) begin
                scratch_q[i] <= scratch_d[i];
            end
        end
    end

    // Write FSM: collect AW and W in any order, commit, then hold B.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            unique case (w_state_q)
                W_IDLE: begin
                    if (aw_fire) begin
                        aw_held_q <= 1'b1;
                        awaddr_q  <= S_AXIL_AWADDR;
                    end
                    if (w_fire) begin
                        w_held_q <= 1'b1;
                        wdata_q  <= S_AXIL_WDATA;
                        wstrb_q  <= S_AXIL_WSTRB;
                    end
                    if (wr_commit) begin
                        w_state_q <= W_RESP;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= wr_oor ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        if (aw_fire) awready_q <= 1'b0;
                        if (w_fire)  wready_q  <= 1'b0;
                    end
                end
                W_RESP: begin
                    if (S_AXIL_BREADY) begin
                        w_state_q <= W_IDLE;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        bvalid_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Read FSM: capture on AR handshake, hold R until accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            unique case (r_state_q)
                R_IDLE: begin
                    if (S_AXIL_ARVALID) begin
                        r_state_q <= R_DATA;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rd_val;
                        rresp_q   <= rd_oor ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                R_DATA: begin
                    if (S_AXIL_RREADY) begin
                        r_state_q <= R_IDLE;
                        arready_q <= 1'b1;
                        rvalid_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign S_AXIL_AWREADY = awready_q;
    assign S_AXIL_WREADY  = wready_q;
    assign S_AXIL_BVALID  = bvalid_q;
    assign S_AXIL_BRESP   = bresp_q;
    assign S_AXIL_ARREADY = arready_q;
    assign S_AXIL_RVALID  = rvalid_q;
    assign S_AXIL_RDATA   = rdata_q;
    assign S_AXIL_RRESP   = rresp_q;
    assign ctrl_o         = ctrl_q;
    assign irq_o          = irq_q;

endmodule
